// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM states, minimum period and period clamp for pwm_multi.
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int PERIOD_MIN = 2;
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'(PERIOD_MIN)) ? 32'(PERIOD_MIN) : p;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with duty/burst shadows, burst counter and registered output.
// Optional PWM_POLARITY_EN adds a per-channel output inversion shadow.
module pwm_channel #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic               i_bnd,
  input  logic               i_ld,
  input  logic               i_run,
  input  logic [CNT_W-1:0]   i_duty,
  input  logic               i_ben,
  input  logic [BURST_W-1:0] i_bcnt,
`ifdef PWM_POLARITY_EN
  input  logic               i_pol,
`endif
  output logic               o_pwm,
  output logic               o_done
);
  logic [CNT_W-1:0]   r_duty;
  logic               r_ben;
  logic [BURST_W-1:0] r_bcnt;
  logic               r_out;
  logic [BURST_W-1:0] w_bcnt_nx;
  logic               w_ben_nx;
  logic               w_hi;
  logic               w_lvl;
`ifdef PWM_POLARITY_EN
  logic               r_pol;
  logic               w_pol_nx;
`endif
  // gate with next burst state so a finished burst is low from the cycle after its last boundary
  always_comb begin
    w_bcnt_nx = i_ld ? i_bcnt : (i_bnd && r_bcnt != '0) ? r_bcnt - BURST_W'(1) : r_bcnt;
    w_ben_nx  = i_ld ? i_ben : r_ben;
    w_hi      = i_run && !(w_ben_nx && w_bcnt_nx == '0) && (i_cnt < r_duty);
`ifdef PWM_POLARITY_EN
    w_pol_nx  = i_ld ? i_pol : r_pol;
    w_lvl     = w_hi ^ w_pol_nx;
`else
    w_lvl     = w_hi;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= '0;
      r_ben  <= 1'b0;
      r_bcnt <= '0;
      r_out  <= 1'b0;
`ifdef PWM_POLARITY_EN
      r_pol  <= 1'b0;
`endif
    end else begin
      if (i_ld) begin
        r_duty <= i_duty;
        r_ben  <= i_ben;
      end
      r_bcnt <= w_bcnt_nx;
      r_out  <= w_lvl;
`ifdef PWM_POLARITY_EN
      r_pol  <= w_pol_nx;
`endif
    end
  end
  assign o_pwm  = r_out;
  assign o_done = r_ben && r_bcnt == '0;
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with shared period counter, shadowed settings and per-channel bursts.
// Define PWM_POLARITY_EN to add the per-channel pol input.
module pwm_multi #(
  parameter int CH      = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                en,
  input  logic [CNT_W-1:0]    period,
  input  logic [CH*CNT_W-1:0] duty,
  input  logic [CH-1:0]       burst_en,
  input  logic [BURST_W-1:0]  burst_cnt,
  input  logic                load,
`ifdef PWM_POLARITY_EN
  input  logic [CH-1:0]       pol,
`endif
  output logic [CH-1:0]       pwm_out,
  output logic                period_tick,
  output logic [CH-1:0]       burst_done,
  output logic                upd_pend,
  output logic                busy
);
  import pwm_pkg::*;
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, r_period, w_period_c;
  logic             r_pend;
  logic             w_act, w_bnd, w_start, w_apply, w_ld, w_run;
  logic [CH-1:0]    w_pwm, w_done;
  // shadows track the live inputs throughout IDLE, so the start edge and idle polarity see fresh values
  always_comb begin
    w_period_c = CNT_W'(clamp_period(32'(period)));
    w_act      = r_state != IDLE;
    w_bnd      = w_act && r_cnt == r_period - CNT_W'(1);
    w_start    = r_state == IDLE && en;
    w_apply    = w_bnd && (r_pend || load);
    w_ld       = r_state == IDLE || w_apply;
    w_state_nx = en ? RUN : (r_state == RUN || (r_state == STOP && !w_bnd)) ? STOP : IDLE;
    w_run      = w_act && w_state_nx != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= (!w_act || w_bnd) ? '0 : r_cnt + CNT_W'(1);
      if (w_ld) r_period <= w_period_c;
      r_pend  <= (w_start || w_apply) ? 1'b0 : (r_pend || load);
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W), .BURST_W(BURST_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_cnt  (r_cnt),
      .i_bnd  (w_bnd),
      .i_ld   (w_ld),
      .i_run  (w_run),
      .i_duty (duty[i*CNT_W +: CNT_W]),
      .i_ben  (burst_en[i]),
      .i_bcnt (burst_cnt),
`ifdef PWM_POLARITY_EN
      .i_pol  (pol[i]),
`endif
      .o_pwm  (w_pwm[i]),
      .o_done (w_done[i])
    );
  end
  assign pwm_out     = w_pwm;
  assign burst_done  = w_done & {CH{w_act}};
  assign period_tick = w_bnd;
  assign upd_pend    = r_pend;
  assign busy        = w_act;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi; expected cycles are queued as stimulus is driven.
module tb_pwm_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] period = '0;
  logic [63:0] duty = '0;
  logic [3:0]  burst_en = '0;
  logic [7:0]  burst_cnt = '0;
  logic        load = 1'b0;
  logic [3:0]  polv = '0;
  logic [3:0]  pwm_out;
  logic        period_tick;
  logic [3:0]  burst_done;
  logic        upd_pend;
  logic        busy;
  int          n_chk = 0;
  int          n_err = 0;
  typedef struct {logic [3:0] pwm; logic tick; logic [3:0] done; logic pend; logic busy;} exp_t;
  exp_t        q[$];

  always #5 clk = ~clk;

  pwm_multi #(.CH(4), .CNT_W(16), .BURST_W(8)) dut (
    .rst        (rst),
    .clk        (clk),
    .en         (en),
    .period     (period),
    .duty       (duty),
    .burst_en   (burst_en),
    .burst_cnt  (burst_cnt),
    .load       (load),
`ifdef PWM_POLARITY_EN
    .pol        (polv),
`endif
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .burst_done (burst_done),
    .upd_pend   (upd_pend),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hi(int k, int k0, int pa, int d);
    return k > k0 && ((k - k0 - 1) % pa) < d;
  endfunction

  task automatic push_raw(input logic [3:0] p, input logic t, input logic [3:0] d, input logic u, input logic b);
    exp_t e;
    e.pwm = p; e.tick = t; e.done = d; e.pend = u; e.busy = b;
    q.push_back(e);
  endtask

  task automatic push(input logic [3:0] p, input logic t, input logic [3:0] d, input logic u, input logic b);
    push_raw(p ^ polv, t, d, u, b);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, " queue"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, " pwm_out"}, 32'(pwm_out), 32'(e.pwm));
      chk({tag, " period_tick"}, 32'(period_tick), 32'(e.tick));
      chk({tag, " burst_done"}, 32'(burst_done), 32'(e.done));
      chk({tag, " upd_pend"}, 32'(upd_pend), 32'(e.pend));
      chk({tag, " busy"}, 32'(busy), 32'(e.busy));
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    @(negedge clk);
    sb_check(tag);
  endtask

  task automatic do_reset(input string tag);
    #1;
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    #1;
    push_raw(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    sb_check({tag, " in_rst"});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
      cyc($sformatf("%s idle%0d", tag, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset("s0");
    // basic pattern, then en drops at cnt=1 of the third period
    period = 16'd10;
    duty = {16'd15, 16'd10, 16'd3, 16'd0};
    for (int k = 0; k < 32; k++) begin
      en = k < 22;
      if (k < 30) push({hi(k, 0, 10, 15), hi(k, 0, 10, 10), hi(k, 0, 10, 3), 1'b0}, k % 10 == 9, 4'b0, 1'b0, 1'b1);
      else push(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
      cyc($sformatf("s1 k=%0d", k));
    end
    // period 0 and 1 clamp to 2
    for (int p = 0; p < 2; p++) begin
      do_reset("s2");
      period = 16'(p);
      duty = {48'd0, 16'd1};
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
        push({3'b0, hi(k, 0, 2, 1)}, k % 2 == 1, 4'b0, 1'b0, 1'b1);
        cyc($sformatf("s2 p=%0d k=%0d", p, k));
      end
    end
    // burst of 3 on ch1, ch0 free-running
    do_reset("s3");
    period = 16'd8;
    duty = {32'd0, 16'd4, 16'd4};
    burst_en = 4'b0010;
    burst_cnt = 8'd3;
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      push({2'b0, hi(k, 0, 8, 4) && (k - 1) / 8 < 3, hi(k, 0, 8, 4)}, k % 8 == 7, {2'b0, k >= 24, 1'b0}, 1'b0, 1'b1);
      cyc($sformatf("s3 k=%0d", k));
    end
    // burst count 0: done at once, no pulses
    do_reset("s3z");
    burst_cnt = 8'd0;
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push({3'b0, hi(k, 0, 8, 4)}, k % 8 == 7, 4'b0010, 1'b0, 1'b1);
      cyc($sformatf("s3z k=%0d", k));
    end
    // mid-period load, then a load coincident with the boundary
    do_reset("s4");
    burst_en = 4'b0;
    period = 16'd10;
    duty = {48'd0, 16'd3};
    en = 1'b1;
    for (int k = 0; k < 37; k++) begin
      load = k == 3 || k == 28;
      if (k == 3) begin period = 16'd6; duty[15:0] = 16'd2; end
      if (k == 28) begin period = 16'd4; duty[15:0] = 16'd1; end
      if (k < 10) push({3'b0, hi(k, 0, 10, 3)}, k == 9, 4'b0, k >= 3, 1'b1);
      else if (k < 28) push({3'b0, hi(k, 10, 6, 2)}, (k - 10) % 6 == 5, 4'b0, 1'b0, 1'b1);
      else push({3'b0, hi(k, 28, 4, 1)}, (k - 28) % 4 == 3, 4'b0, 1'b0, 1'b1);
      cyc($sformatf("s4 k=%0d", k));
    end
    load = 1'b0;
    // reset asserted at cnt=5
    do_reset("s5a");
    period = 16'd10;
    duty = {16'd15, 16'd10, 16'd3, 16'd0};
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push({hi(k, 0, 10, 15), hi(k, 0, 10, 10), hi(k, 0, 10, 3), 1'b0}, k % 10 == 9, 4'b0, 1'b0, 1'b1);
      cyc($sformatf("s5 k=%0d", k));
    end
    do_reset("s5_abort");
`ifdef PWM_POLARITY_EN
    polv = 4'b0010;
    do_reset("s6");
    period = 16'd10;
    duty = {32'd0, 16'd3, 16'd0};
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      push({2'b0, hi(k, 0, 10, 3), 1'b0}, k % 10 == 9, 4'b0, 1'b0, 1'b1);
      cyc($sformatf("s6 k=%0d", k));
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
